// File: rtl/dnn_dot_accel_if.sv
// Avalon-MM bus bundle with master/slave views.
// ADDR_W sets the address width: 4-bit word offset on the CPU side, 32-bit byte address on the memory side.
interface dnn_dot_accel_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/dnn_dot_accel.sv
// Q16.16 dot product bias + sum(w*a); operands fetched one word at a time over mst, optional ReLU under DOT_RELU_EN.
// Latency: start cycle + (RD_W + WT_W + RD_A + WT_A + MAC) per element + DONE.
// Backpressure: slv.waitrequest high whenever not IDLE; mst command held until waitrequest drops, one read outstanding.
module dnn_dot_accel #(
    parameter int FRAC_BITS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    dnn_dot_accel_if.slave  slv,
    dnn_dot_accel_if.master mst
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_W, S_WT_W, S_RD_A, S_WT_A, S_MAC, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] wb_q, wb_d, ab_q, ab_d, bias_q, bias_d, len_q, len_d;
    logic [31:0] result_q, result_d, acc_q, acc_d, idx_q, idx_d;
    logic [31:0] w_q, w_d, a_q, a_d, maddr_q, maddr_d;
    logic        mread_q, mread_d;
`ifdef DOT_RELU_EN
    logic        relu_q, relu_d;
`endif

    logic signed [63:0] w_ext, a_ext, prod;
    logic [31:0]        acc_sum, idx_inc, done_val, rdata;
    logic               unused_prod;

    assign w_ext       = {{32{w_q[31]}}, w_q};
    assign a_ext       = {{32{a_q[31]}}, a_q};
    assign prod        = w_ext * a_ext;
    assign acc_sum     = acc_q + prod[FRAC_BITS+31:FRAC_BITS];
    assign unused_prod = ^{prod[63:FRAC_BITS+32], prod[FRAC_BITS-1:0]};
    assign idx_inc     = idx_q + 32'd1;

`ifdef DOT_RELU_EN
    assign done_val = (relu_q && acc_q[31]) ? 32'd0 : acc_q;
`else
    assign done_val = acc_q;
`endif

    assign slv.waitrequest   = (state_q != S_IDLE);
    assign slv.readdatavalid = 1'b0;
    assign slv.readdata      = rdata;
    assign mst.read          = mread_q;
    assign mst.address       = maddr_q;
    assign mst.write         = 1'b0;
    assign mst.writedata     = 32'd0;

    always_comb begin
        rdata = 32'd0;
        if (slv.read) begin
            case (slv.address)
                4'd0:    rdata = result_q;
                4'd1:    rdata = wb_q;
                4'd2:    rdata = ab_q;
                4'd3:    rdata = bias_q;
                4'd4:    rdata = len_q;
`ifdef DOT_RELU_EN
                4'd5:    rdata = {31'd0, relu_q};
`endif
                default: rdata = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        wb_d     = wb_q;
        ab_d     = ab_q;
        bias_d   = bias_q;
        len_d    = len_q;
        result_d = result_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        w_d      = w_q;
        a_d      = a_q;
        maddr_d  = maddr_q;
        mread_d  = mread_q;
`ifdef DOT_RELU_EN
        relu_d   = relu_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (slv.write) begin
                    case (slv.address)
                        4'd1: wb_d   = slv.writedata;
                        4'd2: ab_d   = slv.writedata;
                        4'd3: bias_d = slv.writedata;
                        4'd4: len_d  = slv.writedata;
`ifdef DOT_RELU_EN
                        4'd5: relu_d = slv.writedata[0];
`endif
                        default: ;
                    endcase
                    if (slv.address == 4'd0) begin
                        acc_d = bias_q;
                        idx_d = 32'd0;
                        if (len_q == 32'd0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RD_W;
                            mread_d = 1'b1;
                            maddr_d = wb_q;
                        end
                    end
                end
            end
            S_RD_W, S_RD_A: begin
                if (!mst.waitrequest) begin
                    mread_d = 1'b0;
                    state_d = (state_q == S_RD_W) ? S_WT_W : S_WT_A;
                end
            end
            S_WT_W: begin
                if (mst.readdatavalid) begin
                    w_d     = mst.readdata;
                    state_d = S_RD_A;
                    mread_d = 1'b1;
                    maddr_d = ab_q + (idx_q << 2);
                end
            end
            S_WT_A: begin
                if (mst.readdatavalid) begin
                    a_d     = mst.readdata;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                idx_d = idx_inc;
                if (idx_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD_W;
                    mread_d = 1'b1;
                    maddr_d = wb_q + (idx_inc << 2);
                end
            end
            S_DONE: begin
                result_d = done_val;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wb_q     <= 32'd0;
            ab_q     <= 32'd0;
            bias_q   <= 32'd0;
            len_q    <= 32'd0;
            result_q <= 32'd0;
            acc_q    <= 32'd0;
            idx_q    <= 32'd0;
            w_q      <= 32'd0;
            a_q      <= 32'd0;
            maddr_q  <= 32'd0;
            mread_q  <= 1'b0;
`ifdef DOT_RELU_EN
            relu_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wb_q     <= wb_d;
            ab_q     <= ab_d;
            bias_q   <= bias_d;
            len_q    <= len_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            w_q      <= w_d;
            a_q      <= a_d;
            maddr_q  <= maddr_d;
            mread_q  <= mread_d;
`ifdef DOT_RELU_EN
            relu_q   <= relu_d;
`endif
        end
    end
endmodule

// File: tb/tb_dnn_dot_accel.sv
// Bench for dnn_dot_accel: CPU register accesses, a configurable-latency memory responder and a fixed-point reference model.
`timescale 1ns/1ps
module tb_dnn_dot_accel;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dnn_dot_accel_if #(.ADDR_W(4))  slv();
    dnn_dot_accel_if #(.ADDR_W(32)) mst();

    dnn_dot_accel dut (.clk(clk), .rst_n(rst_n), .slv(slv), .mst(mst));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder state
    logic [31:0] mem [logic [31:0]];
    int          mem_wait = 0;
    int          mem_lat  = 1;
    int          stall_cnt = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_dat;
    logic [31:0] stall_addr;
    logic [31:0] acc_addr_q[$];
    int          unstable = 0;
    int          busy = 0;
    logic [31:0] wq[$];
    logic [31:0] aq[$];

    initial begin
        mst.waitrequest   = 1'b0;
        mst.readdatavalid = 1'b0;
        mst.readdata      = 32'd0;
        forever begin
            @(negedge clk);
            mst.readdatavalid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mst.readdatavalid = 1'b1;
                    mst.readdata      = pend_dat;
                end
            end
            if (rst_n && mst.read) begin
                if (stall_cnt == 0) stall_addr = mst.address;
                else if (mst.address != stall_addr) unstable++;
                if (stall_cnt < mem_wait) begin
                    mst.waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mst.waitrequest = 1'b0;
                    stall_cnt = 0;
                    acc_addr_q.push_back(mst.address);
                    pend_dat = mem.exists(mst.address) ? mem[mst.address] : 32'hDEAD_BEEF;
                    pend_cnt = mem_lat;
                end
            end else begin
                if (stall_cnt > 0) unstable++;
                mst.waitrequest = (mem_wait > 0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (slv.waitrequest) busy++;
    end

    task automatic cpu_access(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd);
        int t;
        @(negedge clk);
        slv.address = addr; slv.write = wr; slv.read = !wr; slv.writedata = wd;
        #1;
        t = 0;
        while (slv.waitrequest && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 3000) check("cpu_timeout", 32'(t), 32'd0);
        rd = slv.readdata;
        @(posedge clk);
        #1;
        slv.read = 1'b0; slv.write = 1'b0;
    endtask

    task automatic cpu_wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        cpu_access(1'b1, addr, wd, dummy);
    endtask

    function automatic logic [31:0] ref_dot(input logic [31:0] bias, input logic relu);
        logic [31:0] acc;
        longint      p;
        acc = bias;
        for (int i = 0; i < wq.size(); i++) begin
            p   = longint'($signed(wq[i])) * longint'($signed(aq[i]));
            acc = acc + p[47:16];
        end
        if (relu && acc[31]) acc = 32'd0;
        return acc;
    endfunction

    task automatic prog(input logic [31:0] wb, input logic [31:0] ab, input logic [31:0] bias,
                        input logic relu);
        mem.delete();
        for (int i = 0; i < wq.size(); i++) begin
            mem[wb + 32'(4 * i)] = wq[i];
            mem[ab + 32'(4 * i)] = aq[i];
        end
        cpu_wr(4'd1, wb);
        cpu_wr(4'd2, ab);
        cpu_wr(4'd3, bias);
        cpu_wr(4'd4, 32'(wq.size()));
`ifdef DOT_RELU_EN
        cpu_wr(4'd5, {31'd0, relu});
`else
        if (relu) cpu_wr(4'd5, 32'd1);
`endif
    endtask

    task automatic run_dot(input string tag, input logic [31:0] wb, input logic [31:0] ab,
                           input logic [31:0] bias, input int wt, input int k, input logic relu,
                           output logic [31:0] res);
        int          n;
        logic        relu_eff;
        logic [31:0] rb;
        n = wq.size();
        relu_eff = 1'b0;
`ifdef DOT_RELU_EN
        relu_eff = relu;
`endif
        mem_wait = wt;
        mem_lat  = k;
        prog(wb, ab, bias, relu);
        acc_addr_q.delete();
        unstable = 0;
        cpu_wr(4'd0, $urandom);
        busy = 0;
        cpu_access(1'b0, 4'd0, 32'd0, res);
        check({tag, "_result"}, res, ref_dot(bias, relu_eff));
        check({tag, "_nreads"}, 32'(acc_addr_q.size()), 32'(2 * n));
        for (int i = 0; i < n && 2 * i + 1 < acc_addr_q.size(); i++) begin
            check({tag, "_waddr"}, acc_addr_q[2 * i], wb + 32'(4 * i));
            check({tag, "_aaddr"}, acc_addr_q[2 * i + 1], ab + 32'(4 * i));
        end
        check({tag, "_cycles"}, 32'(busy), 32'(n * (2 * (wt + 1 + k) + 1) + 1));
        check({tag, "_stable"}, 32'(unstable), 32'd0);
        cpu_access(1'b0, 4'd1, 32'd0, rb);
        check({tag, "_wb_held"}, rb, wb);
        cpu_access(1'b0, 4'd3, 32'd0, rb);
        check({tag, "_bias_held"}, rb, bias);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res, wb;
        int          n;
        slv.address = 4'd0; slv.read = 1'b0; slv.write = 1'b0; slv.writedata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_waitreq", {31'd0, slv.waitrequest}, 32'd0);
        check("rst_mread", {31'd0, mst.read}, 32'd0);
        check("rst_maddr", mst.address, 32'd0);
        rst_n = 1'b1;
        for (int r = 0; r < 5; r++) begin
            cpu_access(1'b0, 4'(r), 32'd0, res);
            check("rst_reg", res, 32'd0);
        end

        // 2.0 * 3.0
        wq = '{32'h0002_0000}; aq = '{32'h0003_0000};
        run_dot("t1", 32'h0000_1000, 32'h0000_2000, 32'd0, 0, 1, 1'b0, res);
        check("t1_const", res, 32'h0006_0000);

        // 1*4 - 0.5*2 + 2*0.25 + 1 = 4.5
        wq = '{32'h0001_0000, 32'hFFFF_8000, 32'h0002_0000};
        aq = '{32'h0004_0000, 32'h0002_0000, 32'h0000_4000};
        run_dot("t2", 32'h0000_3000, 32'h0000_4000, 32'h0001_0000, 0, 1, 1'b0, res);
        check("t2_const", res, 32'h0004_8000);
        run_dot("t4", 32'h0000_3000, 32'h0000_4000, 32'h0001_0000, 5, 3, 1'b0, res);
        check("t4_const", res, 32'h0004_8000);

        wq.delete(); aq.delete();
        run_dot("t3", 32'h0000_5000, 32'h0000_6000, 32'hFFFF_0000, 0, 1, 1'b0, res);
        check("t3_const", res, 32'hFFFF_0000);
`ifdef DOT_RELU_EN
        run_dot("t3_relu", 32'h0000_5000, 32'h0000_6000, 32'hFFFF_0000, 0, 1, 1'b1, res);
        check("t3_relu_const", res, 32'd0);
        cpu_wr(4'd5, 32'hFFFF_FFFF);
        cpu_access(1'b0, 4'd5, 32'd0, res);
        check("relu_reg", res, 32'd1);
`else
        cpu_wr(4'd5, 32'hFFFF_FFFF);
        cpu_access(1'b0, 4'd5, 32'd0, res);
        check("off5_unused", res, 32'd0);
`endif
        cpu_wr(4'd7, 32'h1234_5678);
        cpu_access(1'b0, 4'd7, 32'd0, res);
        check("off7_unused", res, 32'd0);

        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 6);
            wq.delete(); aq.delete();
            for (int i = 0; i < n; i++) begin
                if (it % 2 == 0) begin
                    wq.push_back($urandom);
                    aq.push_back($urandom);
                end else begin
                    wq.push_back(32'($urandom_range(0, 32'h0007_FFFF)) - 32'h0004_0000);
                    aq.push_back(32'($urandom_range(0, 32'h0007_FFFF)) - 32'h0004_0000);
                end
            end
            wb = (it == 3) ? 32'hFFFF_FFF8 : $urandom;
            run_dot("rnd", wb, wb + 32'h100, $urandom, $urandom_range(0, 3), $urandom_range(1, 4),
                    1'($urandom_range(0, 1)), res);
        end

        // Reset while waiting for an activation word; the late word must be ignored
        wq = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
        aq = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        mem_wait = 0; mem_lat = 6;
        prog(32'h0000_7000, 32'h0000_8000, 32'h0000_1111, 1'b0);
        acc_addr_q.delete();
        cpu_wr(4'd0, 32'd0);
        n = 0;
        while (acc_addr_q.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_wta", 32'(acc_addr_q.size()), 32'd2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_waitreq", {31'd0, slv.waitrequest}, 32'd0);
        check("t6_mread", {31'd0, mst.read}, 32'd0);
        check("t6_noreads", 32'(acc_addr_q.size()), 32'd2);
        cpu_access(1'b0, 4'd0, 32'd0, res);
        check("t6_result_clr", res, 32'd0);
        cpu_access(1'b0, 4'd4, 32'd0, res);
        check("t6_len_clr", res, 32'd0);
        run_dot("t6_rerun", 32'h0000_7000, 32'h0000_8000, 32'h0000_1111, 1, 2, 1'b0, res);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
